// File: rtl/station_pkg.sv
// Shared types and constants for the station controller.
// Opcodes, FSM encoding and the station-ID match helper live here.
package station_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        TRANSIT = 1'b1
    } state_t;

    localparam logic [1:0] OP_STOP = 2'b00;
    localparam logic [1:0] OP_GO   = 2'b01;

    // Upper ID bits every real station tag carries.
    localparam logic [1:0] STN_PREFIX = 2'b00;

    typedef struct packed {
        logic [1:0] op;
        logic [5:0] dst;
    } cmd_t;

    function automatic logic id_hit(
        input logic [7:0] id,
        input logic [5:0] dest
    );
        return (id[7:6] == STN_PREFIX) && (id[5:0] == dest);
    endfunction

endpackage

// File: rtl/buzz_gen.sv
// Piezo divider: square wave of period 2*BUZZ_DIV clocks while enabled.
// Held silent (buzz=0) with the counter parked at its reload value otherwise.
module buzz_gen #(
    parameter int BUZZ_DIV = 12500
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic buzz,
    output logic buzz_n
);

    localparam int CW = (BUZZ_DIV > 1) ? $clog2(BUZZ_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(BUZZ_DIV - 1);

    logic [CW-1:0] cnt;

    // Down-count while enabled; toggle and reload on reaching zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= RELOAD;
            buzz <= 1'b0;
        end else if (!en) begin
            cnt  <= RELOAD;
            buzz <= 1'b0;
        end else if (cnt == '0) begin
            cnt  <= RELOAD;
            buzz <= ~buzz;
        end else begin
            cnt <= cnt - CW'(1);
        end
    end

    assign buzz_n = ~buzz;

endmodule

// File: rtl/station_cntrl.sv
// Station controller: takes GO/STOP commands, tracks the destination,
// ends the trip on a matching barcode, and drives go and the buzzer.
module station_cntrl
    import station_pkg::*;
#(
    parameter int BUZZ_DIV = 12500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_rdy,
    input  logic [7:0] cmd,
    output logic       clr_cmd_rdy,
    input  logic       ID_vld,
    input  logic [7:0] ID,
    output logic       clr_ID_vld,
    input  logic       OK2Move,
    output logic       in_transit,
    output logic       go,
    output logic       buzz,
    output logic       buzz_n
);

    state_t     state;
    logic [5:0] dest_ID;
    cmd_t       cmd_f;
    logic       cmd_acc;
    logic       id_acc;
    logic       buzz_en;

    assign cmd_f = cmd_t'(cmd);

    // A flag still up during its own clear pulse is the same item, not a
    // new one. Commands win a tie; the ID waits a cycle so it is judged
    // against the freshly loaded destination.
    assign cmd_acc = cmd_rdy & ~clr_cmd_rdy;
    assign id_acc  = ID_vld & ~clr_ID_vld & ~cmd_acc;

    // Trip FSM, destination register and consume pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            dest_ID     <= '0;
            clr_cmd_rdy <= 1'b0;
            clr_ID_vld  <= 1'b0;
        end else begin
            clr_cmd_rdy <= cmd_acc;
            clr_ID_vld  <= id_acc;
            unique case (state)
                IDLE: begin
                    if (cmd_acc && cmd_f.op == OP_GO) begin
                        dest_ID <= cmd_f.dst;
                        state   <= TRANSIT;
                    end
                end
                TRANSIT: begin
                    if (cmd_acc) begin
                        if (cmd_f.op == OP_GO) begin
                            dest_ID <= cmd_f.dst;
                        end else if (cmd_f.op == OP_STOP) begin
                            state <= IDLE;
                        end
                    end else if (id_acc && id_hit(ID, dest_ID)) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign in_transit = (state == TRANSIT);

    // Motion enable, one cycle behind trip state and obstacle sensor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            go <= 1'b0;
        end else begin
            go <= in_transit & OK2Move;
        end
    end

    assign buzz_en = in_transit & ~OK2Move;

    buzz_gen #(
        .BUZZ_DIV(BUZZ_DIV)
    ) u_buzz (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (buzz_en),
        .buzz  (buzz),
        .buzz_n(buzz_n)
    );

endmodule

// File: tb/tb_station_cntrl.sv
// Testbench for station_cntrl: directed scenarios plus random traffic
// checked against a trip-level reference model.
module tb_station_cntrl;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_rdy = 1'b0;
    logic [7:0] cmd = '0;
    logic       ID_vld = 1'b0;
    logic [7:0] ID = '0;
    logic       OK2Move = 1'b0;
    logic       clr_cmd_rdy;
    logic       clr_ID_vld;
    logic       in_transit;
    logic       go;
    logic       buzz;
    logic       buzz_n;

    int errs = 0;
    int checks = 0;

    // Reference model state
    bit       m_st;
    bit [5:0] m_dest;
    int       m_run;
    bit       m_go;
    bit       m_cc;
    bit       m_ci;

    station_cntrl #(.BUZZ_DIV(DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_rdy    (cmd_rdy),
        .cmd        (cmd),
        .clr_cmd_rdy(clr_cmd_rdy),
        .ID_vld     (ID_vld),
        .ID         (ID),
        .clr_ID_vld (clr_ID_vld),
        .OK2Move    (OK2Move),
        .in_transit (in_transit),
        .go         (go),
        .buzz       (buzz),
        .buzz_n     (buzz_n)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_st = 0; m_dest = 0; m_run = 0;
        m_go = 0; m_cc = 0; m_ci = 0;
    endtask

    // One clock edge of the trip rules.
    task automatic model_step();
        bit en;
        en = m_st && !OK2Move;
        m_go = m_st && OK2Move;
        m_run = en ? m_run + 1 : 0;
        m_cc = 0;
        m_ci = 0;
        if (cmd_rdy) begin
            m_cc = 1;
            if (cmd[7:6] == 2'b01) begin
                m_dest = cmd[5:0];
                m_st = 1;
            end else if (cmd[7:6] == 2'b00) begin
                m_st = 0;
            end
        end else if (ID_vld) begin
            m_ci = 1;
            if (m_st && ID[7:6] == 2'b00 && ID[5:0] == m_dest)
                m_st = 0;
        end
    endtask

    // Buzzer level after m_run consecutive enabled edges.
    function automatic bit m_buzz();
        return ((m_run / DIV) % 2) == 1;
    endfunction

    // Advance one clock; sample point is the following falling edge,
    // where the bench (as receiver) withdraws consumed items.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (m_cc) cmd_rdy = 0;
        if (m_ci) ID_vld = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; cmd_rdy = 0; ID_vld = 0; OK2Move = 0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (in_transit !== m_st) begin errs++;
            $display("FAIL rst_transit: got %b want %b", in_transit, m_st); end
        checks++;
        if (go !== m_go) begin errs++;
            $display("FAIL rst_go: got %b want %b", go, m_go); end
        checks++;
        if (clr_cmd_rdy !== m_cc) begin errs++;
            $display("FAIL rst_clr_cmd: got %b want %b", clr_cmd_rdy, m_cc); end
        checks++;
        if (clr_ID_vld !== m_ci) begin errs++;
            $display("FAIL rst_clr_id: got %b want %b", clr_ID_vld, m_ci); end
        checks++;
        if (buzz !== m_buzz() || buzz_n !== !m_buzz()) begin errs++;
            $display("FAIL rst_buzz: got %b/%b want %b", buzz, buzz_n, m_buzz()); end
        checks++;
        if (dut.dest_ID !== m_dest) begin errs++;
            $display("FAIL rst_dest: got %h want %h", dut.dest_ID, m_dest); end
        rst_n = 1;
    endtask

    task automatic test_go_cmd();
        OK2Move = 1; cmd = 8'h45; cmd_rdy = 1;
        tick();
        checks++;
        if (clr_cmd_rdy !== m_cc || !m_cc) begin errs++;
            $display("FAIL go_clr: got %b want 1", clr_cmd_rdy); end
        checks++;
        if (in_transit !== m_st) begin errs++;
            $display("FAIL go_transit: got %b want %b", in_transit, m_st); end
        tick();
        checks++;
        if (clr_cmd_rdy !== m_cc) begin errs++;
            $display("FAIL go_clr_end: got %b want %b", clr_cmd_rdy, m_cc); end
        checks++;
        if (go !== m_go) begin errs++;
            $display("FAIL go_go: got %b want %b", go, m_go); end
        checks++;
        if (dut.dest_ID !== m_dest) begin errs++;
            $display("FAIL go_dest: got %h want %h", dut.dest_ID, m_dest); end
    endtask

    task automatic test_id_match();
        logic [7:0] ids [3] = '{8'h03, 8'h45, 8'h05};
        for (int i = 0; i < 3; i++) begin
            ID = ids[i]; ID_vld = 1;
            tick();
            checks++;
            if (clr_ID_vld !== m_ci) begin errs++;
                $display("FAIL id_clr%0d: got %b want %b", i, clr_ID_vld, m_ci); end
            checks++;
            if (in_transit !== m_st) begin errs++;
                $display("FAIL id_transit%0d: got %b want %b", i, in_transit, m_st); end
            tick();
            checks++;
            if (clr_ID_vld !== m_ci) begin errs++;
                $display("FAIL id_clr_end%0d: got %b want %b", i, clr_ID_vld, m_ci); end
        end
        checks++;
        if (go !== m_go) begin errs++;
            $display("FAIL id_go: got %b want %b", go, m_go); end
    endtask

    task automatic test_buzz();
        OK2Move = 0; cmd = 8'h45; cmd_rdy = 1;
        tick();
        for (int i = 0; i < 13; i++) begin
            tick();
            checks++;
            if (buzz !== m_buzz() || buzz_n !== !m_buzz() || go !== m_go) begin
                errs++;
                $display("FAIL buzz%0d: got b=%b bn=%b go=%b want b=%b go=%b",
                         i, buzz, buzz_n, go, m_buzz(), m_go);
            end
        end
        OK2Move = 1;
        tick();
        checks++;
        if (buzz !== m_buzz() || go !== m_go) begin errs++;
            $display("FAIL buzz_off: got b=%b go=%b want b=%b go=%b",
                     buzz, go, m_buzz(), m_go); end
    endtask

    task automatic test_collision();
        cmd = 8'h4A; cmd_rdy = 1; ID = 8'h0A; ID_vld = 1;
        tick();
        checks++;
        if (clr_cmd_rdy !== m_cc || clr_ID_vld !== m_ci) begin errs++;
            $display("FAIL col_first: got c=%b i=%b want c=%b i=%b",
                     clr_cmd_rdy, clr_ID_vld, m_cc, m_ci); end
        checks++;
        if (dut.dest_ID !== m_dest) begin errs++;
            $display("FAIL col_dest: got %h want %h", dut.dest_ID, m_dest); end
        tick();
        checks++;
        if (clr_cmd_rdy !== m_cc || clr_ID_vld !== m_ci) begin errs++;
            $display("FAIL col_second: got c=%b i=%b want c=%b i=%b",
                     clr_cmd_rdy, clr_ID_vld, m_cc, m_ci); end
        checks++;
        if (in_transit !== m_st) begin errs++;
            $display("FAIL col_arrive: got %b want %b", in_transit, m_st); end
        tick();
    endtask

    task automatic test_stop_ignored();
        logic [7:0] seq [3] = '{8'h45, 8'h00, 8'hC5};
        for (int i = 0; i < 3; i++) begin
            cmd = seq[i]; cmd_rdy = 1;
            tick();
            checks++;
            if (clr_cmd_rdy !== m_cc || in_transit !== m_st) begin errs++;
                $display("FAIL cmd%0d: got c=%b t=%b want c=%b t=%b",
                         i, clr_cmd_rdy, in_transit, m_cc, m_st); end
            tick();
        end
        ID = 8'h05; ID_vld = 1;
        tick();
        checks++;
        if (clr_ID_vld !== m_ci || in_transit !== m_st) begin errs++;
            $display("FAIL idle_id: got i=%b t=%b want i=%b t=%b",
                     clr_ID_vld, in_transit, m_ci, m_st); end
        tick();
        checks++;
        if (dut.dest_ID !== m_dest) begin errs++;
            $display("FAIL idle_dest: got %h want %h", dut.dest_ID, m_dest); end
    endtask

    task automatic test_async_reset();
        OK2Move = 0; cmd = 8'h45; cmd_rdy = 1;
        repeat (7) tick();
        checks++;
        if (buzz !== m_buzz() || in_transit !== m_st) begin errs++;
            $display("FAIL pre_rst: got b=%b t=%b want b=%b t=%b",
                     buzz, in_transit, m_buzz(), m_st); end
        #2 rst_n = 0;
        #1 model_reset();
        checks++;
        if ({in_transit, go, clr_cmd_rdy, clr_ID_vld, buzz, buzz_n} !==
            {m_st, m_go, m_cc, m_ci, m_buzz(), !m_buzz()}) begin errs++;
            $display("FAIL async_rst: got t%b g%b c%b i%b b%b bn%b",
                     in_transit, go, clr_cmd_rdy, clr_ID_vld, buzz, buzz_n); end
        checks++;
        if (dut.dest_ID !== m_dest) begin errs++;
            $display("FAIL async_dest: got %h want %h", dut.dest_ID, m_dest); end
        @(negedge clk);
        rst_n = 1; OK2Move = 1;
        repeat (4) tick();
        checks++;
        if (in_transit !== m_st || go !== m_go) begin errs++;
            $display("FAIL post_rst: got t=%b g=%b want t=%b g=%b",
                     in_transit, go, m_st, m_go); end
    endtask

    task automatic test_random();
        logic [1:0] hi;
        for (int n = 0; n < 500; n++) begin
            if (!cmd_rdy && !m_cc && $urandom_range(3) == 0) begin
                cmd = {2'($urandom_range(3)), 6'($urandom_range(7))};
                cmd_rdy = 1;
            end
            if (!ID_vld && !m_ci && $urandom_range(2) == 0) begin
                hi = ($urandom_range(4) == 0) ? 2'($urandom_range(3)) : 2'b00;
                ID = {hi, 6'($urandom_range(7))};
                ID_vld = 1;
            end
            if ($urandom_range(7) == 0) OK2Move = ~OK2Move;
            tick();
            checks++;
            if ({in_transit, go, clr_cmd_rdy, clr_ID_vld, buzz, buzz_n} !==
                {m_st, m_go, m_cc, m_ci, m_buzz(), !m_buzz()} ||
                dut.dest_ID !== m_dest) begin
                errs++;
                $display("FAIL rnd%0d: got t%b g%b c%b i%b b%b bn%b d%h want t%b g%b c%b i%b b%b d%h",
                         n, in_transit, go, clr_cmd_rdy, clr_ID_vld, buzz,
                         buzz_n, dut.dest_ID, m_st, m_go, m_cc, m_ci,
                         m_buzz(), m_dest);
            end
            checks++;
            if (clr_cmd_rdy && clr_ID_vld) begin errs++;
                $display("FAIL rnd_both_clr%0d: got 1 want 0", n); end
        end
    endtask

    initial begin
        test_reset();
        test_go_cmd();
        test_id_match();
        test_buzz();
        test_collision();
        test_stop_ignored();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/station_cntrl.md
STATION_CNTRL -- requirements
Module: station_cntrl

Interface
REQ-001 Parameter BUZZ_DIV, default 12500, clk cycles per buzzer half-period.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 cmd_rdy  input  1  command byte available from the serial command receiver.
REQ-005 cmd  input  8  command byte; [7:6] opcode, [5:0] destination station.
REQ-006 clr_cmd_rdy  output  1  one-cycle pulse consuming the current command.
REQ-007 ID_vld  input  1  barcode reader holds a decoded station ID.
REQ-008 ID  input  8  decoded station ID; [7:6] must be 2'b00 for a valid station.
REQ-009 clr_ID_vld  output  1  one-cycle pulse consuming the current ID.
REQ-010 OK2Move  input  1  path clear, no obstacle.
REQ-011 in_transit  output  1  a trip toward a destination station is active.
REQ-012 go  output  1  motion enable to the motor controller.
REQ-013 buzz  output  1  piezo drive; buzz_n  output  1  its complement.

Function
REQ-014 FSM states: IDLE, TRANSIT; in_transit SHALL be 1 exactly in TRANSIT.
REQ-015 Opcodes: 2'b01 = GO (load dest_ID = cmd[5:0]); 2'b00 = STOP; 2'b10, 2'b11 ignored.
REQ-016 Every cycle with cmd_rdy=1 handled by the FSM SHALL assert clr_cmd_rdy for exactly one cycle, including ignored opcodes.
REQ-017 IDLE + cmd_rdy + GO -> load dest_ID, TRANSIT next cycle.
REQ-018 IDLE + cmd_rdy + STOP -> stay IDLE.
REQ-019 TRANSIT + cmd_rdy + GO -> reload dest_ID, stay TRANSIT (retarget).
REQ-020 TRANSIT + cmd_rdy + STOP -> IDLE next cycle.
REQ-021 ID_vld SHALL be consumed with a one-cycle clr_ID_vld pulse in both states.
REQ-022 TRANSIT + ID_vld, ID[7:6]=2'b00, ID[5:0]=dest_ID -> IDLE next cycle (arrived).
REQ-023 TRANSIT + ID_vld with mismatch or ID[7:6]!=2'b00 -> cleared, stay TRANSIT.
REQ-024 IDLE + ID_vld -> cleared, no state change.
REQ-025 cmd_rdy and ID_vld in the same cycle: command processed, clr_ID_vld withheld; ID evaluated the next cycle against the updated dest_ID.
REQ-026 clr_cmd_rdy and clr_ID_vld SHALL never assert in the same cycle.
REQ-027 go SHALL equal in_transit & OK2Move, registered (one-cycle latency from state/OK2Move change).
REQ-028 Buzzer active when in_transit=1 and OK2Move=0; buzz toggles every BUZZ_DIV cycles via a down-counter reloaded on toggle.
REQ-029 Buzzer inactive: counter held at BUZZ_DIV-1, buzz=0, buzz_n=1.
REQ-030 buzz_n SHALL always equal ~buzz.
REQ-031 dest_ID SHALL be 6 bits and retain its value across IDLE.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE, dest_ID=0, in_transit=0, go=0, clr_cmd_rdy=0, clr_ID_vld=0, buzz=0, buzz_n=1, buzzer counter=BUZZ_DIV-1.
REQ-033 Reset mid-trip SHALL abandon the trip; a new GO is required after release.
REQ-034 First command or ID is accepted on the first rising edge after rst_n release.

Structure
REQ-035 Opcode constants (GO, STOP) and the state encoding SHALL reside in a shared package station_pkg.
REQ-036 Buzzer divider SHALL be a sub-module buzz_gen (inputs en; outputs buzz, buzz_n; parameter BUZZ_DIV).
REQ-037 FSM, dest_ID register, and pulse generation SHALL remain in station_cntrl.

Verification
REQ-038 Reset, cmd=8'h45 with cmd_rdy -> clr_cmd_rdy one-cycle pulse, in_transit=1, dest_ID=6'h05, go=1 with OK2Move=1.
REQ-039 In TRANSIT to 6'h05, ID=8'h03 then ID=8'h45 with ID_vld -> first: clr_ID_vld pulse, stays TRANSIT; second: clr_ID_vld pulse, stays TRANSIT; then ID=8'h05 -> IDLE, go=0.
REQ-040 TRANSIT with OK2Move=0 and BUZZ_DIV=4 -> go=0, buzz toggles every 4 cycles, buzz_n=~buzz; OK2Move=1 -> buzz=0, go=1.
REQ-041 Same cycle cmd=8'h4A (cmd_rdy) and ID=8'h0A (ID_vld) while targeting 6'h05 -> clr_cmd_rdy first, clr_ID_vld next cycle, then arrival -> IDLE.
REQ-042 TRANSIT, cmd=8'h00 -> IDLE; cmd=8'hC5 in IDLE -> clr_cmd_rdy pulse, stays IDLE.
REQ-043 rst_n asserted mid-TRANSIT while buzzing -> all outputs at reset values asynchronously; no motion until a new GO.
